// File: rtl/firing_pkg.sv
// Shared definitions for the firing path: datapath command codes, the
// sequencing state encoding and the magazine size.
// No ports.
package firing_pkg;

   localparam logic [2:0] CTRL_RELOAD = 3'b000;
   localparam logic [2:0] CTRL_HOLD   = 3'b001;
   localparam logic [2:0] CTRL_SHOT   = 3'b011;

   localparam logic [1:0] MAX_SHOTS   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RELOAD   = 3'd1,
      S_ARMED    = 3'd2,
      S_FIRE     = 3'd3,
      S_CHECK    = 3'd4,
      S_COOLDOWN = 3'd5,
      S_EMPTY    = 3'd6
   } fc_state_e;

   // Timer lengths of 0 behave as 1 so every terminal-count compare stays valid.
   function automatic int at_least_one(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/firing_control_if.sv
// Bundle between firing_control and its neighbours (firing datapath and
// duck collision checker).
//   control          3-bit datapath command (RELOAD/HOLD/SHOT)
//   remaining_shots  ammo count reported by the datapath
//   hit_query        level request to the collision checker
//   hit_valid        collision result strobe
//   hit_result       1 = duck hit, valid with hit_valid
//   shot_x/shot_y    crosshair position captured at fire
// master = firing_control side, slave = datapath/collision side.
interface firing_control_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7
);
   logic [2:0]     control;
   logic [1:0]     remaining_shots;
   logic           hit_query;
   logic           hit_valid;
   logic           hit_result;
   logic [X_W-1:0] shot_x;
   logic [Y_W-1:0] shot_y;

   modport master (
      output control, hit_query, shot_x, shot_y,
      input  remaining_shots, hit_valid, hit_result
   );

   modport slave (
      input  control, hit_query, shot_x, shot_y,
      output remaining_shots, hit_valid, hit_result
   );
endinterface

// File: rtl/firing_control_trigger_conditioner.sv
// trigger_conditioner: brings the raw trigger button into the clk domain
// and produces a one-cycle pulse on each press.
//   clk, reset_n   clock, asynchronous active-low reset
//   trigger        raw asynchronous button level
//   trig_edge      one-cycle pulse, two cycles after the pin rises
// Build option TRIGGER_DEBOUNCE_EN inserts a stability filter of
// DEBOUNCE_CYCLES cycles between the synchroniser and the edge detector.
module trigger_conditioner
   import firing_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic trigger,
   output logic trig_edge
);

   logic sync_1, sync_2;
   logic level, level_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= trigger;
         sync_2 <= sync_1;
      end
   end

`ifdef TRIGGER_DEBOUNCE_EN
   localparam int DB_EFF = at_least_one(DEBOUNCE_CYCLES);
   localparam int DB_W   = $clog2(DB_EFF + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_EFF - 1);

   logic [DB_W-1:0] db_cnt;
   logic            db_level;

   // Down-counter reloads while input agrees with the filtered level; the
   // level only flips after DB_EFF consecutive disagreeing cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
      end else if (sync_2 == db_level) begin
         db_cnt <= DB_LAST;
      end else if (db_cnt == '0) begin
         db_level <= sync_2;
         db_cnt   <= DB_LAST;
      end else begin
         db_cnt <= db_cnt - 1'b1;
      end
   end

   assign level = db_level;
`else
   assign level = sync_2;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) level_d <= 1'b0;
      else          level_d <= level;
   end

   assign trig_edge = level & ~level_d;

endmodule

// File: rtl/firing_control.sv
// firing_control: sequencing FSM in front of the firing datapath. Turns
// trigger presses into single SHOT commands, reloads at round start, runs
// the hit-check handshake and enforces a cooldown between shots.
//   clk, reset_n         clock, asynchronous active-low reset
//   trigger              raw trigger button
//   round_start          one-cycle pulse: refill ammo and arm
//   cross_x/cross_y      live crosshair
//   bus (master)         datapath control/ammo and collision handshake
//   hit/miss/dry_fire    one-cycle result pulses
//   out_of_ammo, busy    status levels
// Build option TRIGGER_DEBOUNCE_EN enables trigger debouncing.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | before first round, trigger ignored
// RELOAD   | one cycle of RELOAD command to the datapath
// ARMED    | waiting for a trigger press
// FIRE     | one cycle of SHOT, crosshair captured
// CHECK    | hit_query raised, waiting for hit_valid or timeout
// COOLDOWN | fixed dead time after a shot
// EMPTY    | no ammo, presses only produce dry_fire
module firing_control
   import firing_pkg::*;
#(
   parameter int COOLDOWN_CYCLES = 12_500_000,
   parameter int CHECK_TIMEOUT   = 1024,
   parameter int X_W             = 8,
   parameter int Y_W             = 7,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           trigger,
   input  logic           round_start,
   input  logic [X_W-1:0] cross_x,
   input  logic [Y_W-1:0] cross_y,
   firing_control_if.master bus,
   output logic           hit,
   output logic           miss,
   output logic           dry_fire,
   output logic           out_of_ammo,
   output logic           busy
);

   localparam logic [2:0] ST_IDLE     = S_IDLE;
   localparam logic [2:0] ST_RELOAD   = S_RELOAD;
   localparam logic [2:0] ST_ARMED    = S_ARMED;
   localparam logic [2:0] ST_FIRE     = S_FIRE;
   localparam logic [2:0] ST_CHECK    = S_CHECK;
   localparam logic [2:0] ST_COOLDOWN = S_COOLDOWN;
   localparam logic [2:0] ST_EMPTY    = S_EMPTY;

   localparam int CT_EFF = at_least_one(CHECK_TIMEOUT);
   localparam int CT_W   = $clog2(CT_EFF + 1);
   localparam logic [CT_W-1:0] CT_LAST = CT_W'(CT_EFF - 1);

   localparam int CD_EFF = at_least_one(COOLDOWN_CYCLES);
   localparam int CD_W   = $clog2(CD_EFF + 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(CD_EFF - 1);

   logic [2:0]      state, state_nxt;
   logic [CT_W-1:0] to_cnt;
   logic [CD_W-1:0] cd_cnt;
   logic            trig_edge;
   logic            hit_nxt, miss_nxt, dry_nxt;
   logic [X_W-1:0]  shot_x;
   logic [Y_W-1:0]  shot_y;
   logic            have_ammo;

   trigger_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_trig (
      .clk      (clk),
      .reset_n  (reset_n),
      .trigger  (trigger),
      .trig_edge(trig_edge)
   );

   assign have_ammo = (bus.remaining_shots != 2'd0);

   // round_start overrides every state, including an in-flight CHECK,
   // so an aborted shot produces neither hit nor miss.
   always_comb begin
      state_nxt = state;
      hit_nxt   = 1'b0;
      miss_nxt  = 1'b0;
      dry_nxt   = 1'b0;
      if (round_start) begin
         state_nxt = ST_RELOAD;
      end else begin
         case (state)
            ST_IDLE:   state_nxt = ST_IDLE;
            ST_RELOAD: state_nxt = ST_ARMED;
            ST_ARMED: begin
               if (trig_edge) begin
                  if (have_ammo) begin
                     state_nxt = ST_FIRE;
                  end else begin
                     state_nxt = ST_EMPTY;
                     dry_nxt   = 1'b1;
                  end
               end
            end
            ST_FIRE:   state_nxt = ST_CHECK;
            ST_CHECK: begin
               if (bus.hit_valid) begin
                  hit_nxt   = bus.hit_result;
                  miss_nxt  = ~bus.hit_result;
                  state_nxt = ST_COOLDOWN;
               end else if (to_cnt == CT_LAST) begin
                  miss_nxt  = 1'b1;
                  state_nxt = ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (cd_cnt == '0) state_nxt = have_ammo ? ST_ARMED : ST_EMPTY;
            end
            ST_EMPTY:  dry_nxt = trig_edge;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         hit      <= 1'b0;
         miss     <= 1'b0;
         dry_fire <= 1'b0;
         shot_x   <= '0;
         shot_y   <= '0;
         to_cnt   <= '0;
         cd_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         hit      <= hit_nxt;
         miss     <= miss_nxt;
         dry_fire <= dry_nxt;
         if (state == ST_FIRE) begin
            shot_x <= cross_x;
            shot_y <= cross_y;
            to_cnt <= '0;
         end else if (state == ST_CHECK) begin
            to_cnt <= to_cnt + 1'b1;
         end
         // Cooldown down-counter is loaded on the way out of CHECK.
         if (state == ST_CHECK && state_nxt == ST_COOLDOWN) begin
            cd_cnt <= CD_LAST;
         end else if (state == ST_COOLDOWN && cd_cnt != '0) begin
            cd_cnt <= cd_cnt - 1'b1;
         end
      end
   end

   assign bus.control   = (state == ST_RELOAD) ? CTRL_RELOAD :
                          (state == ST_FIRE)   ? CTRL_SHOT   : CTRL_HOLD;
   assign bus.hit_query = (state == ST_CHECK);
   assign bus.shot_x    = shot_x;
   assign bus.shot_y    = shot_y;
   assign out_of_ammo   = (state == ST_EMPTY);
   assign busy          = (state == ST_FIRE) || (state == ST_CHECK) ||
                          (state == ST_COOLDOWN) || (state == ST_RELOAD);

endmodule

// File: tb/tb_firing_control.sv
module tb_firing_control;
   import firing_pkg::*;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int CD  = 4;
   localparam int CT  = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic trigger = 1'b0;
   logic round_start = 1'b0;
   logic [X_W-1:0] cross_x = '0;
   logic [Y_W-1:0] cross_y = '0;
   logic hit, miss, dry_fire, out_of_ammo, busy;

   firing_control_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

   firing_control #(
      .COOLDOWN_CYCLES(CD),
      .CHECK_TIMEOUT  (CT),
      .X_W            (X_W),
      .Y_W            (Y_W),
      .DEBOUNCE_CYCLES(16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .trigger    (trigger),
      .round_start(round_start),
      .cross_x    (cross_x),
      .cross_y    (cross_y),
      .bus        (bus),
      .hit        (hit),
      .miss       (miss),
      .dry_fire   (dry_fire),
      .out_of_ammo(out_of_ammo),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_RELOAD, EV_SHOT, EV_HIT, EV_MISS, EV_DRY} ev_kind_e;
   typedef struct {ev_kind_e kind; int cycle; int x; int y;} ev_t;
   typedef struct {int cycle; int sig; int val;} lvl_t;

   ev_t  exp_q[$];
   lvl_t lvl_q[$];

   int checks = 0;
   int failures = 0;
   bit done = 1'b0;
   bit xy_due = 1'b0;
   int exp_x, exp_y;
   int ammo = 0;

   string sig_name[6] = '{"control", "busy", "out_of_ammo", "hit_query", "shot_x", "pulses"};

   function automatic int sig_val(input int s);
      case (s)
         0:       return int'(bus.control);
         1:       return int'(busy);
         2:       return int'(out_of_ammo);
         3:       return int'(bus.hit_query);
         4:       return int'(bus.shot_x);
         default: return int'({hit, miss, dry_fire});
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic take(input ev_kind_e k);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event actual=%s@%0d required=none", k.name(), cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cycle != cyc) begin
            failures++;
            $display("FAIL event actual=%s@%0d required=%s@%0d", k.name(), cyc, e.kind.name(), e.cycle);
         end else if (k == EV_SHOT) begin
            xy_due = 1'b1;
            exp_x  = e.x;
            exp_y  = e.y;
         end
      end
   endtask

   always @(negedge clk) begin
      lvl_t l;
      while (lvl_q.size() > 0 && lvl_q[0].cycle <= cyc) begin
         l = lvl_q.pop_front();
         checks++;
         if (l.cycle != cyc || sig_val(l.sig) != l.val) begin
            failures++;
            $display("FAIL lvl_%s cycle=%0d due=%0d actual=%0d required=%0d",
                     sig_name[l.sig], cyc, l.cycle, sig_val(l.sig), l.val);
         end
      end
      if (!reset_n) begin
         xy_due = 1'b0;
      end else begin
         if (xy_due) begin
            checks++;
            if (int'(bus.shot_x) != exp_x || int'(bus.shot_y) != exp_y) begin
               failures++;
               $display("FAIL shot_xy actual=(%0d,%0d) required=(%0d,%0d)",
                        bus.shot_x, bus.shot_y, exp_x, exp_y);
            end
            xy_due = 1'b0;
         end
         if (bus.control == CTRL_RELOAD)    take(EV_RELOAD);
         else if (bus.control == CTRL_SHOT) take(EV_SHOT);
         else if (bus.control != CTRL_HOLD) begin
            checks++;
            failures++;
            $display("FAIL control_code actual=%b required=000/001/011", bus.control);
         end
         if (hit)      take(EV_HIT);
         if (miss)     take(EV_MISS);
         if (dry_fire) take(EV_DRY);
      end
      if (done) begin
         checks++;
         if (exp_q.size() != 0 || lvl_q.size() != 0) begin
            failures++;
            $display("FAIL leftover actual=%0d/%0d pending required=0/0", exp_q.size(), lvl_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog actual=cycle %0d required=finish", cyc);
      $fatal(1);
   end

   // ---------------- stimulus + reference model ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lvl(input int c, input int s, input int v);
      lvl_q.push_back(lvl_t'{c, s, v});
   endtask

   task automatic set_ammo(input int n);
      ammo = n;
      bus.remaining_shots = 2'(n);
   endtask

   task automatic do_round_start();
      round_start = 1'b1;
      exp_q.push_back(ev_t'{EV_RELOAD, cyc + 1, 0, 0});
      lvl(cyc + 1, 1, 1);
      tick();
      round_start = 1'b0;
      set_ammo(int'(MAX_SHOTS));
      tick();
   endtask

   // One trigger press while ARMED with ammo. Timeline from the press cycle
   // t0: trig_edge seen at t0+3 so SHOT shows at t0+3; CHECK spans t0+4 ..
   // t0+4+CT-1; a result strobe at cycle h is scored at h+1; cooldown lasts
   // CD cycles starting at the result pulse.
   task automatic do_shot(input int nx, input int ny, input int d, input bit res,
                          input int drop_mode, input int abort_mode,
                          output bit aborted, output int e);
      int t0, hv, a, p, last, k;
      t0 = cyc;
      hv = t0 + 4 + d;
      a = -100;
      p = -100;
      aborted = (abort_mode == 2) || (abort_mode == 1 && $urandom_range(0, 5) == 0);
      exp_q.push_back(ev_t'{EV_SHOT, t0 + 3, nx, ny});
      if (aborted) begin
         k = $urandom_range(0, (d < CT - 1) ? d : CT - 1);
         a = t0 + 4 + k;
         e = a + 1;
         exp_q.push_back(ev_t'{EV_RELOAD, a + 1, 0, 0});
         lvl(a + 1, 3, 0);
         last = (hv > a + 2) ? hv : a + 2;
      end else begin
         e = (d <= CT - 1) ? t0 + 5 + d : t0 + 4 + CT;
         exp_q.push_back(ev_t'{(d <= CT - 1 && res) ? EV_HIT : EV_MISS, e, 0, 0});
         lvl(t0 + 4, 1, 1);
         if (d <= CT - 1) lvl(hv, 3, 1);
         lvl(e, 3, 0);
         if (drop_mode == 1 && $urandom_range(0, 1) == 1) p = $urandom_range(t0 + 3, e + 1);
         last = e + 2;
         if (p + 3 > last) last = p + 3;
         if (hv + 1 > last) last = hv + 1;
      end
      for (int c = t0; c <= last; c++) begin
         trigger = (c == t0 || c == t0 + 1 || c == p || c == p + 1);
         if (c <= t0 + 3) begin
            cross_x = X_W'(nx);
            cross_y = Y_W'(ny);
         end else begin
            cross_x = X_W'($urandom);
            cross_y = Y_W'($urandom);
         end
         round_start    = aborted && (c == a);
         bus.hit_valid  = (c == hv);
         bus.hit_result = (c == hv) ? res : 1'($urandom);
         if (c == t0 + 4) set_ammo(ammo - 1);
         if (aborted && c == a + 1) set_ammo(int'(MAX_SHOTS));
         tick();
      end
      trigger = 1'b0;
      round_start = 1'b0;
      bus.hit_valid = 1'b0;
   endtask

   // Press while EMPTY (or ARMED with zero ammo): dry_fire only.
   task automatic dry_press(input bit from_armed);
      int t;
      t = cyc;
      exp_q.push_back(ev_t'{EV_DRY, t + 3, 0, 0});
      lvl(t + 3, 0, int'(CTRL_HOLD));
      lvl(t + 3 + (from_armed ? 0 : 1), 2, 1);
      for (int c = 0; c < 6; c++) begin
         trigger = (c < 2);
         tick();
      end
   endtask

   task automatic check_empty_after(input int e);
      int c;
      c = (cyc > e + 4) ? cyc : e + 4;
      lvl(c, 2, 1);
      lvl(c, 1, 0);
      while (cyc <= c) tick();
   endtask

   initial begin
      bit ab;
      int e;
      int shots;
      bus.remaining_shots = 2'd0;
      bus.hit_valid = 1'b0;
      bus.hit_result = 1'b0;
      for (int s = 0; s < 6; s++) lvl(1, s, (s == 0) ? int'(CTRL_HOLD) : 0);
      tick(); tick(); tick();
      reset_n = 1'b1;
      tick();

      // IDLE ignores the trigger
      lvl(cyc + 3, 0, int'(CTRL_HOLD));
      lvl(cyc + 4, 1, 0);
      for (int c = 0; c < 6; c++) begin
         trigger = (c < 2);
         tick();
      end

      // directed round: hit, timeout miss, third shot with dropped press, then empty
      do_round_start();
      do_shot(40, 20, 3, 1'b1, 0, 0, ab, e);
      do_shot(7, 99, 9, 1'b1, 0, 0, ab, e);
      do_shot(255, 127, 7, 1'b0, 1, 0, ab, e);
      check_empty_after(e);
      dry_press(1'b0);

      // directed abort in CHECK
      do_round_start();
      do_shot(12, 34, 6, 1'b1, 0, 2, ab, e);
      tick();

      // random rounds
      for (int r = 0; r < 10; r++) begin
         do_round_start();
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 4) == 0) begin
            set_ammo(0);
            tick();
            dry_press(1'b1);
            continue;
         end
         shots = 0;
         ab = 1'b0;
         while (ammo > 0 && shots < 8) begin
            do_shot($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 10),
                    1'($urandom), 1, 1, ab, e);
            shots++;
            repeat ($urandom_range(0, 2)) tick();
         end
         if (ammo == 0 && !ab) begin
            check_empty_after(e);
            dry_press(1'b0);
         end
      end

      // asynchronous reset in the middle of COOLDOWN
      do_round_start();
      do_shot(1, 2, 0, 1'b0, 0, 0, ab, e);
      lvl(cyc, 0, int'(CTRL_HOLD));
      lvl(cyc, 1, 0);
      lvl(cyc, 2, 0);
      lvl(cyc, 3, 0);
      #2;
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      done = 1'b1;
   end

endmodule
